rx_frame_decoder: RTL

- Sits directly downstream of the RX bit aligner and consumes its aligned beat stream, `sof` and `rx_aligned`.
- Assembles N_FRAME_CYCLE beats into one frame and checks the 2-bit sync header.
- Descrambles the payload with the self-synchronous x^58+x^39+1 polynomial.
- Emits one payload word per frame, with frame type and error counters, to the RX flow-control/FIFO stage.

---
 rtl/rx_frame_decoder.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/rx_frame_decoder.sv
// rx_frame_decoder: builds frames from aligned beats, checks the 2-bit sync header and emits one payload per frame.
// Optional build macro RX_DESCRAMBLE_EN enables the x^58+x^39+1 self-synchronous descrambler and first-frame warmup.
module rx_frame_decoder #(
  parameter int DWIDTH      = 64,
  parameter int FRAME_WIDTH = 256
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [DWIDTH-1:0]      rxdata_aligned_in,
  input  logic                   sof_in,
  input  logic                   rx_aligned_in,
  output logic                   frame_valid,
  output logic [FRAME_WIDTH-3:0] frame_payload,
  output logic                   frame_type,
  output logic [15:0]            hdr_err_cnt,
  output logic [15:0]            sync_err_cnt,
  output logic                   rx_frame_up
);

  localparam int N_FRAME_CYCLE = FRAME_WIDTH / DWIDTH;
  localparam int PW            = FRAME_WIDTH - 2;
  localparam int CW            = (N_FRAME_CYCLE > 1) ? $clog2(N_FRAME_CYCLE) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(N_FRAME_CYCLE - 1);

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_HUNT     = 2'd1,
    ST_WARMUP   = 2'd2,
    ST_RUN      = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   beat_cnt_q, beat_cnt_d;
  logic            frame_valid_q, frame_valid_d;
  logic [PW-1:0]   frame_payload_q, frame_payload_d;
  logic            frame_type_q, frame_type_d;
  logic [15:0]     hdr_err_cnt_q, hdr_err_cnt_d;
  logic [15:0]     sync_err_cnt_q, sync_err_cnt_d;
  logic            rx_frame_up_q, rx_frame_up_d;

  logic            cap_en;
  logic [CW-1:0]   cap_idx;
  logic            frame_done;
  logic            hdr_inc;
  logic            sync_inc;
  logic [FRAME_WIDTH-1:0] frame_full;
  logic [1:0]      hdr;
  logic            hdr_ok;
  logic [PW-1:0]   payload_raw;
  logic [PW-1:0]   payload_out;

  // The last beat is never stored: completion uses it straight from the input.
  generate
    if (N_FRAME_CYCLE > 1) begin : g_buf
      localparam int BW = FRAME_WIDTH - DWIDTH;
      logic [BW-1:0] frame_buf_q, frame_buf_d;

      always_comb begin
        frame_buf_d = frame_buf_q;
        for (int k = 0; k < N_FRAME_CYCLE - 1; k++) begin
          if (cap_en && (cap_idx == CW'(k))) begin
            frame_buf_d[BW-1-k*DWIDTH -: DWIDTH] = rxdata_aligned_in;
          end
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          frame_buf_q <= '0;
        end else begin
          frame_buf_q <= frame_buf_d;
        end
      end

      assign frame_full = {frame_buf_q, rxdata_aligned_in};
    end else begin : g_nobuf
      assign frame_full = rxdata_aligned_in;
    end
  endgenerate

  assign hdr         = frame_full[FRAME_WIDTH-1 -: 2];
  assign hdr_ok      = (hdr == 2'b10) || (hdr == 2'b01);
  assign payload_raw = frame_full[PW-1:0];

`ifdef RX_DESCRAMBLE_EN
  localparam bit DESCRAMBLE = 1'b1;
  // History MSB is the oldest bit; it holds the last 58 scrambled bits of completed frames.
  logic [57:0] desc_hist_q, desc_hist_d;

  assign desc_hist_d = frame_done ? payload_raw[57:0] : desc_hist_q;
  assign payload_out = payload_raw
                     ^ {desc_hist_q[38:0], payload_raw[PW-1:39]}
                     ^ {desc_hist_q,       payload_raw[PW-1:58]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      desc_hist_q <= '0;
    end else begin
      desc_hist_q <= desc_hist_d;
    end
  end
`else
  localparam bit DESCRAMBLE = 1'b0;
  assign payload_out = payload_raw;
`endif

  always_comb begin
    state_d         = state_q;
    beat_cnt_d      = beat_cnt_q;
    frame_valid_d   = 1'b0;
    frame_payload_d = frame_payload_q;
    frame_type_d    = frame_type_q;
    cap_en          = 1'b0;
    cap_idx         = beat_cnt_q;
    frame_done      = 1'b0;
    hdr_inc         = 1'b0;
    sync_inc        = 1'b0;

    if (!rx_aligned_in) begin
      state_d    = ST_UNLOCKED;
      beat_cnt_d = '0;
    end else begin
      case (state_q)
        ST_UNLOCKED: begin
          state_d    = ST_HUNT;
          beat_cnt_d = '0;
        end
        ST_HUNT: begin
          if (sof_in) begin
            cap_en  = 1'b1;
            cap_idx = '0;
            state_d = DESCRAMBLE ? ST_WARMUP : ST_RUN;
          end
        end
        default: begin
          if (sof_in && (beat_cnt_q != '0)) begin
            // Restart the frame on the early sof; state is kept.
            sync_inc = 1'b1;
            cap_en   = 1'b1;
            cap_idx  = '0;
          end else if ((N_FRAME_CYCLE > 1) && (beat_cnt_q == '0) && !sof_in) begin
            sync_inc   = 1'b1;
            state_d    = ST_HUNT;
            beat_cnt_d = '0;
          end else begin
            cap_en     = 1'b1;
            frame_done = (beat_cnt_q == LAST_BEAT);
          end
        end
      endcase

      if (cap_en) begin
        beat_cnt_d = (cap_idx == LAST_BEAT) ? '0 : cap_idx + 1'b1;
      end

      if (frame_done) begin
        if (hdr_ok) begin
          if (state_q == ST_RUN) begin
            frame_valid_d   = 1'b1;
            frame_payload_d = payload_out;
            frame_type_d    = (hdr == 2'b01);
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          hdr_inc = 1'b1;
        end
      end
    end

    hdr_err_cnt_d  = (hdr_inc && (hdr_err_cnt_q != 16'hFFFF)) ? hdr_err_cnt_q + 16'd1 : hdr_err_cnt_q;
    sync_err_cnt_d = (sync_inc && (sync_err_cnt_q != 16'hFFFF)) ? sync_err_cnt_q + 16'd1 : sync_err_cnt_q;
    rx_frame_up_d  = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_UNLOCKED;
      beat_cnt_q      <= '0;
      frame_valid_q   <= 1'b0;
      frame_payload_q <= '0;
      frame_type_q    <= 1'b0;
      hdr_err_cnt_q   <= '0;
      sync_err_cnt_q  <= '0;
      rx_frame_up_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      beat_cnt_q      <= beat_cnt_d;
      frame_valid_q   <= frame_valid_d;
      frame_payload_q <= frame_payload_d;
      frame_type_q    <= frame_type_d;
      hdr_err_cnt_q   <= hdr_err_cnt_d;
      sync_err_cnt_q  <= sync_err_cnt_d;
      rx_frame_up_q   <= rx_frame_up_d;
    end
  end

  assign frame_valid   = frame_valid_q;
  assign frame_payload = frame_payload_q;
  assign frame_type    = frame_type_q;
  assign hdr_err_cnt   = hdr_err_cnt_q;
  assign sync_err_cnt  = sync_err_cnt_q;
  assign rx_frame_up   = rx_frame_up_q;

endmodule
